t5_hsch: RTL
============

# t5_hsch

Hart scheduler for the four-hart barrel pipeline. It holds one program counter per hart and picks one enabled hart per advancing cycle in round-robin order. It presents the registered fetch address `fpc`, with the hart id in `fpc[1:0]`, to instruction fetch and the decode stage. It also accepts branch/jump redirects from execute and writes them into the owning hart's PC.

## Interface
- `XLEN`, default 32: datapath width.
- `RESET_PC`, default 32'h0000_0000: start address for all harts. Bits [1:0] are ignored.
- `sclk`  in  1: clock, rising edge.
- `srst`  in  1: reset, synchronous, active-low. Sampled on the `sclk` rising edge while 0.
- `sena`  in  1: pipeline advance. The scheduler issues one slot only on edges where `sena`=1.
- `hen`  in  4: per-hart enable mask. Bit h=1 makes hart h eligible. Sampled combinationally at each issue.
- `bra`  in  1: redirect valid.
- `bpc`  in  XLEN: redirect target. `bpc[1:0]` is the target hart id, `bpc[XLEN-1:2]` is the word address.
- `fpc`  out  XLEN: fetch address, `{pc_word, hart}`.
- `fval`  out  1: the `fpc` slot holds a real instruction (0 = bubble).
- `fcnt`  out  2: number of enabled harts minus one (0 when 0 or 1 harts are enabled). Diagnostic.

## Operation
- State:
  - four PC registers `pc[h]`, each XLEN-2 bits;
  - a 2-bit last-issued pointer `ptr`;
  - output registers `fpc`, `fval`.
- Selection, evaluated on each `sena`=1 edge:
  - Candidate h = first hart with `hen`[h]=1, searching ptr+1, ptr+2, ptr+3, ptr+4, all mod 4.
  - The current `ptr` is checked last, so a sole enabled hart issues every cycle.
- Issue when a candidate exists:
  - `fpc` <= {pc[h], h};
  - `fval` <= 1;
  - `ptr` <= h;
  - `pc[h]` <= pc[h]+1, word increment that wraps at 2^(XLEN-2) with no carry into the hart bits.
- No enabled hart:
  - `fval` <= 0;
  - `fpc`, `ptr` and all `pc` hold.
- `sena`=0:
  - `fpc`, `fval`, `ptr` and the issue increment all hold.
- Redirect, on any edge with `bra`=1, independent of `sena`:
  - `pc[bpc[1:0]]` <= `bpc[XLEN-1:2]`.
  - This applies even when the target hart is disabled.
- Redirect and issue to the same hart on the same edge:
  - The redirect wins the PC write and the increment is discarded.
  - `fpc` still shows the pre-redirect pc (no bypass). Squashing that slot is the execute stage's job.
- Redirect to a different hart than the one being issued: both PC updates happen on that edge.
- `hen` changes take effect at the next selection. A hart disabled mid-stream keeps its pc and resumes from it when re-enabled.
- `fcnt` = popcount(`hen`)-1, saturating at 0. It is combinational from `hen`.

## Timing
- Reset values (`srst`=0 at an edge):
  - all `pc[h]` = `RESET_PC[XLEN-1:2]`;
  - `ptr` = 3, so hart 0 is the first candidate;
  - `fpc` = {`RESET_PC[XLEN-1:2]`, 2'b00};
  - `fval` = 0.
- Reset overrides `sena` and `bra`.
- Reset asserted mid-stream discards all PCs and pending redirects on that edge.
- Issue latency: `fpc`/`fval` are valid from the `sena` edge that performed the selection. They are registered outputs with no combinational path from inputs.
- Redirect latency: the redirected hart's next issue, on any edge after the `bra` edge, fetches `bpc`. The earliest is the following edge.
- With all four harts enabled and `sena` held at 1, the issue order is 0,1,2,3,0,…. Each hart issues exactly once every 4 cycles.
- Throughput: one slot per `sena` cycle; a bubble occurs only when `hen`=0.

## Test plan
- **Reset and full round-robin.** `RESET_PC`=0x100, `hen`=4'hF, `sena`=1 after reset release.
  - Required `fpc` sequence: 0x100, 0x101, 0x102, 0x103, 0x104, 0x105, …
  - `fval`=1 throughout; `fval`=0 while in reset.
- **Sparse mask.** `hen`=4'b1010.
  - Harts 1,3,1,3 alternate; each hart's word increments by 1 per own issue.
  - Change `hen` to 4'b0100: the next slot is hart 2 at its untouched reset pc.
- **Redirect.** `hen`=4'hF, `bra`=1 with `bpc`=0x2002.
  - The next hart-2 slot shows `fpc`=0x2002; the slot after that shows 0x2006.
  - Other harts are unaffected.
- **Same-edge collision.** Redirect hart 0 to 0x400 on the edge that issues hart 0 at 0x100.
  - That slot shows 0x100.
  - The next hart-0 slot shows 0x400, not 0x104.
- **Stall and empty.**
  - `sena`=0 for 3 cycles: `fpc`/`fval` hold, and a `bra` during the stall still takes effect.
  - `hen`=0: `fval`=0 and `fpc` holds.
  - Restore `hen`: the next slot is the first enabled hart after `ptr`.
- **Wrap and mid-run reset.**
  - Hart with word 0x3FFF_FFFF: its next slot is `fpc`={0x0,h}.
  - Assert `srst`=0 for one edge mid-run: all harts restart at `RESET_PC`, first from hart 0.

Source files
------------

// File: rtl/t5_hsch.sv
// Four-hart barrel scheduler: per-hart PC registers, round-robin issue of one
// enabled hart per advancing cycle, and execute-stage redirects into hart PCs.

module t5_hsch_pc #(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic [XLEN-3:0] rst_word,
    input  logic            inc,
    input  logic            wr,
    input  logic [XLEN-3:0] wdata,
    output logic [XLEN-3:0] pc
);
    // A redirect beats the issue increment; the slot already issued keeps the old pc.
    always_ff @(posedge sclk) begin
        if (!srst)
            pc <= rst_word;
        else if (wr)
            pc <= wdata;
        else if (inc)
            pc <= pc + 1'b1;
    end
endmodule

module t5_hsch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [3:0]      hen,
    input  logic            bra,
    input  logic [XLEN-1:0] bpc,
    output logic [XLEN-1:0] fpc,
    output logic            fval,
    output logic [1:0]      fcnt
);
    localparam int NUM_HARTS = 4;

    logic [NUM_HARTS-1:0][XLEN-3:0] pc;
    logic [1:0]                     ptr;
    logic [1:0]                     cand;
    logic [1:0]                     idx;
    logic                           cand_vld;
    logic                           issue;
    logic [2:0]                     hcnt;

    // Search ptr+1 .. ptr+4; the current ptr comes last so a lone hart still issues.
    always_comb begin
        cand_vld = 1'b0;
        cand     = ptr;
        idx      = ptr;
        for (int i = 1; i <= NUM_HARTS; i++) begin
            idx = ptr + 2'(i);
            if (!cand_vld && hen[idx]) begin
                cand_vld = 1'b1;
                cand     = idx;
            end
        end
    end

    assign issue = sena && cand_vld;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        t5_hsch_pc #(.XLEN(XLEN)) u_pc (
            .sclk     (sclk),
            .srst     (srst),
            .rst_word (RESET_PC[XLEN-1:2]),
            .inc      (issue && (cand == 2'(h))),
            .wr       (bra && (bpc[1:0] == 2'(h))),
            .wdata    (bpc[XLEN-1:2]),
            .pc       (pc[h])
        );
    end

    always_ff @(posedge sclk) begin
        if (!srst) begin
            ptr  <= 2'd3;
            fpc  <= {RESET_PC[XLEN-1:2], 2'b00};
            fval <= 1'b0;
        end else if (sena) begin
            if (cand_vld) begin
                fpc  <= {pc[cand], cand};
                fval <= 1'b1;
                ptr  <= cand;
            end else begin
                fval <= 1'b0;
            end
        end
    end

    always_comb begin
        hcnt = 3'(hen[0]) + 3'(hen[1]) + 3'(hen[2]) + 3'(hen[3]);
        fcnt = (hcnt == 3'd0) ? 2'd0 : 2'(hcnt - 3'd1);
    end
endmodule
